// File: rtl/slide_index_gen.sv
// Slide index generator: streams (dst, src, oob) index beats for vslideup/vslidedown.
// Optional perf counters (perf_beats, perf_stalls) are enabled with SLIDE_IDX_PERF_CNT_EN.
module slide_index_gen #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_dir,
  input  logic [N-1:0] cmd_offset,
  input  logic [N-1:0] cmd_vl,
  input  logic [N-1:0] cmd_vlmax,
  output logic         idx_valid,
  input  logic         idx_ready,
  output logic [N-1:0] idx_dst,
  output logic [N-1:0] idx_src,
  output logic         idx_oob,
  output logic         idx_last,
`ifdef SLIDE_IDX_PERF_CNT_EN
  output logic [31:0]  perf_beats,
  output logic [31:0]  perf_stalls,
`endif
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t       state;
  logic         dir_r;
  logic [N-1:0] off_r;
  logic [N-1:0] vl_r;
  logic [N-1:0] vlmax_r;
  logic [N-1:0] cnt;
  logic [N-1:0] cnt_nxt;
  logic [N:0]   calc_first;
  logic [N:0]   calc_next;

  // Returns {oob, src[N-1:0]}; bit N of the N+1 bit sum is the carry (down) or borrow (up).
  function automatic logic [N:0] calc(input logic dir, input logic [N-1:0] i,
                                      input logic [N-1:0] off, input logic [N-1:0] vmax);
    logic [N:0] s;
    s = dir ? ({1'b0, i} - {1'b0, off}) : ({1'b0, i} + {1'b0, off});
    return {s[N] | (s[N-1:0] >= vmax), s[N-1:0]};
  endfunction

  assign cnt_nxt    = cnt + 1'b1;
  assign calc_first = calc(cmd_dir, '0, cmd_offset, cmd_vlmax);
  assign calc_next  = calc(dir_r, cnt_nxt, off_r, vlmax_r);
  assign idx_dst    = cnt;

  // Beat fields for element i+1 are precomputed so accepted beats follow back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      idx_valid <= 1'b0;
      cnt       <= '0;
      idx_src   <= '0;
      idx_oob   <= 1'b0;
      idx_last  <= 1'b0;
      done      <= 1'b0;
      dir_r     <= 1'b0;
      off_r     <= '0;
      vl_r      <= '0;
      vlmax_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd_valid) begin
            if (cmd_vl == '0) begin
              done <= 1'b1;
            end else begin
              dir_r     <= cmd_dir;
              off_r     <= cmd_offset;
              vl_r      <= cmd_vl;
              vlmax_r   <= cmd_vlmax;
              cnt       <= '0;
              idx_src   <= calc_first[N-1:0];
              idx_oob   <= calc_first[N];
              idx_last  <= (cmd_vl == N'(1));
              idx_valid <= 1'b1;
              cmd_ready <= 1'b0;
              state     <= RUN;
            end
          end
        end
        RUN: begin
          if (idx_ready) begin
            if (idx_last) begin
              idx_valid <= 1'b0;
              idx_last  <= 1'b0;
              done      <= 1'b1;
              state     <= FIN;
            end else begin
              cnt      <= cnt_nxt;
              idx_src  <= calc_next[N-1:0];
              idx_oob  <= calc_next[N];
              idx_last <= (cnt_nxt == vl_r - 1'b1);
            end
          end
        end
        FIN: begin
          done      <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          idx_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SLIDE_IDX_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_beats  <= '0;
      perf_stalls <= '0;
    end else begin
      if (idx_valid && idx_ready && (perf_beats != '1))
        perf_beats <= perf_beats + 1'b1;
      if (idx_valid && !idx_ready && (perf_stalls != '1))
        perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_slide_index_gen.sv
// Self-checking bench for slide_index_gen: directed plan cases plus randomized commands.
module tb_slide_index_gen;

  localparam longint unsigned M = 64'h1_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [31:0] cmd_offset;
  logic [31:0] cmd_vl;
  logic [31:0] cmd_vlmax;
  logic        idx_valid;
  logic        idx_ready;
  logic [31:0] idx_dst;
  logic [31:0] idx_src;
  logic        idx_oob;
  logic        idx_last;
  logic        done;
`ifdef SLIDE_IDX_PERF_CNT_EN
  logic [31:0] perf_beats;
  logic [31:0] perf_stalls;
`endif

  int checks = 0;
  int errors = 0;

  slide_index_gen #(.N(32)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_offset(cmd_offset), .cmd_vl(cmd_vl), .cmd_vlmax(cmd_vlmax),
    .idx_valid(idx_valid), .idx_ready(idx_ready), .idx_dst(idx_dst),
    .idx_src(idx_src), .idx_oob(idx_oob), .idx_last(idx_last),
`ifdef SLIDE_IDX_PERF_CNT_EN
    .perf_beats(perf_beats), .perf_stalls(perf_stalls),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: source index from plain integer arithmetic on unbounded values.
  task automatic ref_beat(input bit dir, input longint unsigned i, input longint unsigned off,
                          input longint unsigned vmax, output longint unsigned src, output bit oob);
    longint unsigned s;
    if (!dir) begin
      s   = i + off;
      src = s % M;
      oob = (s >= M) || (src >= vmax);
    end else begin
      src = (i + M - off) % M;
      oob = (i < off) || (src >= vmax);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rmode: 0 = always ready, 1 = random, 2 = pattern pat (LSB first, then ready)
  task automatic run_cmd(input bit dir, input longint unsigned off, input longint unsigned vl,
                         input longint unsigned vmax, input int rmode, input bit [15:0] pat,
                         input bit noise);
    longint unsigned i, src;
    bit oob, rdy;
    int k, n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_offset = off[31:0];
    cmd_vl     = vl[31:0];
    cmd_vlmax  = vmax[31:0];
    tick();
    cmd_valid  = noise;
    cmd_dir    = ~dir;
    cmd_offset = 32'd5;
    cmd_vl     = 32'd7;
    cmd_vlmax  = 32'd3;
    if (vl == 0) begin
      check("vl0_no_valid", idx_valid, 0);
      check("vl0_done", done, 1);
      check("vl0_ready", cmd_ready, 1);
      cmd_valid = 1'b0;
      tick();
      check("vl0_done_clr", done, 0);
      return;
    end
    i = 0;
    k = 0;
    while (i < vl && k < 200) begin
      ref_beat(dir, i, off, vmax, src, oob);
      check("valid", idx_valid, 1);
      check("busy", cmd_ready, 0);
      check("dst", idx_dst, i);
      check("src", idx_src, src);
      check("oob", idx_oob, oob);
      check("last", idx_last, (i == vl - 1));
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (k < 16) ? pat[k] : 1'b1;
      endcase
      idx_ready = rdy;
      tick();
      k++;
      if (rdy) i++;
    end
    check("beat_count", i, vl);
    cmd_valid = 1'b0;
    idx_ready = 1'($urandom_range(0, 1));
    check("done", done, 1);
    check("done_no_valid", idx_valid, 0);
    tick();
    check("done_clr", done, 0);
    check("idle_ready", cmd_ready, 1);
  endtask

  initial begin
    longint unsigned off, vmax, vl;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_dir    = 1'b0;
    cmd_offset = '0;
    cmd_vl     = '0;
    cmd_vlmax  = '0;
    idx_ready  = 1'b0;
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_valid", idx_valid, 0);
    check("rst_dst", idx_dst, 0);
    check("rst_src", idx_src, 0);
    check("rst_oob", idx_oob, 0);
    check("rst_last", idx_last, 0);
    check("rst_done", done, 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    run_cmd(1'b0, 2, 4, 4, 0, '0, 1'b0);
    run_cmd(1'b1, 3, 4, 8, 0, '0, 1'b0);
    run_cmd(1'b0, 1, 3, 8, 2, 16'b11001, 1'b0);
    run_cmd(1'b0, 64'hFFFF_FFFF, 3, 64'hFFFF_FFFF, 0, '0, 1'b0);
    run_cmd(1'b0, 0, 0, 4, 0, '0, 1'b0);
    run_cmd(1'b0, 0, 5, 3, 0, '0, 1'b1);
    run_cmd(1'b1, 0, 1, 0, 1, '0, 1'b0);

    // Asynchronous reset in the middle of a command, after beat 1 is accepted.
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_offset = 32'd1; cmd_vl = 32'd8; cmd_vlmax = 32'd8;
    idx_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("mid_dst", idx_dst, 2);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", idx_valid, 0);
    check("arst_ready", cmd_ready, 1);
    check("arst_dst", idx_dst, 0);
    check("arst_src", idx_src, 0);
    check("arst_last", idx_last, 0);
    tick();
    rst = 1'b0;
    run_cmd(1'b1, 2, 5, 6, 1, '0, 1'b0);

    for (int t = 0; t < 14; t++) begin
      off  = ($urandom_range(0, 3) == 0) ? (M - longint'($urandom_range(1, 4))) : longint'($urandom_range(0, 12));
      vmax = ($urandom_range(0, 4) == 0) ? (M - 1) : longint'($urandom_range(0, 16));
      vl   = longint'($urandom_range(0, 10));
      run_cmd(1'($urandom_range(0, 1)), off, vl, vmax, 1, '0, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
